mul_seq: RTL
============

Name: mul_seq

Overview:
Parametrised sequential shift-add multiplier. It is the multi-cycle, area-lean successor to the combinational 4x4 multipliers, generalised to WIDTH_A x WIDTH_B operands with a per-transaction signed/unsigned mode and valid/ready handshakes on both sides. It sits between a producer and a consumer that tolerate WIDTH_B-cycle latency. The bench reuses the existing compare-against-golden flow.

Parameters:
WIDTH_A, 8, multiplicand width (>=2)
WIDTH_B, 8, multiplier width, also the iteration count (>=2)
CNT_W, $clog2(WIDTH_B+1), derived iteration counter width; do not override

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH_A  multiplicand
b  in  WIDTH_B  multiplier
is_signed  in  1  1 = a and b are two's complement; sampled with a/b
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
p  out  WIDTH_A+WIDTH_B  product, two's complement when the accepted is_signed=1

Behaviour:
- Reset (rst=0, async assert, sync release): state=IDLE, in_ready=1, out_valid=0, p=0, accumulator/counter/sign regs=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - Accept on a rising edge with in_valid&&in_ready.
  - On accept, latch |a| and |b| (absolute values only when is_signed=1, else raw). Magnitudes are unsigned, so -2^(W-1) fits.
  - Also latch neg = is_signed & (a[MSB]^b[MSB]). Clear the accumulator, set cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: if mb[0], acc += ma << cnt; then mb >>= 1 and cnt++.
  - After the edge where cnt reaches WIDTH_B-1, go to DONE. At that same edge load p with acc (negated if neg).
  - No early termination. Latency is fixed.
- DONE:
  - out_valid=1, and p is held stable while out_valid && !out_ready.
  - On out_valid&&out_ready, go to IDLE and drop out_valid the next cycle. p keeps its value.
- Latency: out_valid is first high WIDTH_B cycles after the accept edge.
- Throughput: with out_ready tied high, one product per WIDTH_B+2 cycles. in_ready is high only in IDLE; there is no overlap.
- in_valid while busy is ignored. a/b/is_signed may change freely outside the accept edge.
- Width: the accumulator is WIDTH_A+WIDTH_B bits and the unsigned product never overflows. The signed result is an exact two's-complement product of full width.
  - Example: -2^(A-1) * -2^(B-1) = 2^(A+B-2) is representable.
- Zero operands still take the full WIDTH_B cycles.
- Reset mid-RUN or mid-DONE aborts immediately to the reset values. The pending product is lost and nothing is emitted after release.
- No X propagation: a/b are only sampled on the accept edge.

Decomposition:
- Package mul_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - function for the conditional two's-complement negate
- Natural sub-module: mul_cneg (parametrised width; y = neg ? -x : x, combinational).
  - Instanced for |a| and |b|, each driven by its operand MSB & is_signed.
  - Instanced for the final product, driven by neg.

Test Plan:
- WIDTH_A=WIDTH_B=4, is_signed=0, exhaustive 16x16 with out_ready=1 -> every p == a*b. Also compare to mul/mul_lrtl outputs; print "not equal" on mismatch and expect zero prints.
- WIDTH 4x4, is_signed=1, corner cases:
  - a=4'h8, b=4'h8 -> p=8'h40
  - a=4'h8, b=4'h7 -> p=8'hC8
  - a=4'hF, b=4'h1 -> p=8'hFF
  - a=0, b=4'h8 -> p=8'h00
- Latency/handshake, default 8x8:
  - accept a=8'd200, b=8'd3 at edge k -> out_valid rises after edge k+8 with p=16'd600
  - in_ready returns high the cycle after the out handshake
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> p and out_valid stay stable, and in_ready=0 throughout. Then out_ready=1 for one cycle -> out_valid=0 next cycle.
- Busy-ignore: while in RUN, drive in_valid=1 with a=8'hFF, b=8'hFF -> the current product is unaffected. The new pair is accepted only once back in IDLE.
- Reset mid-operation: assert rst=0 asynchronously (between edges) during RUN cycle 3 -> outputs go to reset values immediately. After release, no out_valid appears until a new accept.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the bit-serial two's-complement negate step.
package mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

  // One bit of a conditional negate: -x flips every bit above the lowest set bit.
  function automatic logic cneg_bit(input logic neg, input logic x, input logic seen_one);
    return x ^ (neg & seen_one);
  endfunction

endpackage

// File: rtl/mul_cneg.sv
// Conditional two's-complement negate, y = neg ? -x : x, any width.
module mul_cneg
  import mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  always_comb begin
    logic seen_one;
    seen_one = 1'b0;
    y = '0;
    for (int i = 0; i < W; i++) begin
      y[i] = cneg_bit(neg, x[i], seen_one);
      seen_one = seen_one | x[i];
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, WIDTH_A x WIDTH_B, signed or unsigned per
// transaction, fixed WIDTH_B-cycle latency, valid/ready on both sides.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int CNT_W   = $clog2(WIDTH_B + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  input  logic                       is_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] p,
  output logic [1:0]                 dbg_state
);

  localparam int PW = WIDTH_A + WIDTH_B;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on valid, and valid holds until accepted.

  state_t              state, state_nxt;
  logic [WIDTH_A-1:0]  ma, abs_a;
  logic [WIDTH_B-1:0]  mb, abs_b;
  logic [PW-1:0]       acc, acc_nxt, p_fin;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic                last;

  mul_cneg #(.W(WIDTH_A)) u_abs_a (
    .x   (a),
    .neg (is_signed & a[WIDTH_A-1]),
    .y   (abs_a)
  );

  mul_cneg #(.W(WIDTH_B)) u_abs_b (
    .x   (b),
    .neg (is_signed & b[WIDTH_B-1]),
    .y   (abs_b)
  );

  // Final sign fix operates on the accumulator value including the last add.
  mul_cneg #(.W(PW)) u_fix (
    .x   (acc_nxt),
    .neg (neg),
    .y   (p_fin)
  );

  assign acc_nxt   = acc + (mb[0] ? ({{WIDTH_B{1'b0}}, ma} << cnt) : '0);
  assign last      = (cnt == CNT_W'(WIDTH_B - 1));
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma  <= '0;
      mb  <= '0;
      neg <= 1'b0;
      acc <= '0;
      cnt <= '0;
      p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ma  <= abs_a;
            mb  <= abs_b;
            neg <= is_signed & (a[WIDTH_A-1] ^ b[WIDTH_B-1]);
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          mb  <= mb >> 1;
          cnt <= cnt + 1'b1;
          if (last) p <= p_fin;
        end
        default: ;
      endcase
    end
  end

endmodule
